// File: rtl/sensor_debounce_sync.sv
// Input conditioning for the irrigation controller: two-flop synchroniser, per-channel
// stability-counter debounce, registered edge pulses and a sticky all-quiet flag.
module sensor_debounce_sync #(
    parameter int N_CH     = 7,
    parameter int DEBOUNCE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            settled
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(DEBOUNCE);

    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;
    logic [N_CH-1:0] diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             clean_reg;
            logic             clean_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;

            // A change is only accepted after DEBOUNCE consecutive disagreeing samples;
            // any agreeing sample in between restarts the count.
            always_comb begin
                cnt_next   = cnt_reg;
                clean_next = clean_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                if (sync2_reg[gi] == clean_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    clean_next = sync2_reg[gi];
                    rise_next  = sync2_reg[gi];
                    fall_next  = ~sync2_reg[gi];
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    clean_reg <= clean_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

            assign clean_out[gi]  = clean_reg;
            assign rise_pulse[gi] = rise_reg;
            assign fall_pulse[gi] = fall_reg;
        end
    endgenerate

    assign diff = sync2_reg ^ clean_out;

    logic [CNT_W-1:0] scnt_reg;
    logic [CNT_W-1:0] scnt_next;
    logic             settled_reg;
    logic             settled_next;

    // Settle counter saturates so a long quiet period cannot wrap it.
    always_comb begin
        scnt_next = scnt_reg;
        if (|diff) begin
            scnt_next = '0;
        end else if (scnt_reg != SETTLE_MAX) begin
            scnt_next = scnt_reg + CNT_ONE;
        end
        settled_next = settled_reg | (scnt_reg == SETTLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_reg    <= '0;
            settled_reg <= 1'b0;
        end else begin
            scnt_reg    <= scnt_next;
            settled_reg <= settled_next;
        end
    end

    assign settled = settled_reg;

endmodule

// File: tb/tb_sensor_debounce_sync.sv
// Bench for sensor_debounce_sync: directed scenarios plus random traffic, checked
// against a window-based reference model of the synchronise/debounce rules.
module tb_sensor_debounce_sync;

    localparam int N = 7;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] clean_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         settled;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] m_clean = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;
    logic         m_settled = 1'b0;
    logic [N-1:0] raw_q[$];
    logic [N-1:0] s2_q[$];
    bit           diff_q[$];

    sensor_debounce_sync #(.N_CH(N), .DEBOUNCE(D), .CNT_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .clean_out(clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        raw_q.delete();
        s2_q.delete();
        diff_q.delete();
        m_clean   = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_settled = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    // One clock edge: the synchronised view of a pin lags the pin by two edges; a level
    // is accepted once it has disagreed with the clean value for D edges in a row.
    task automatic step();
        logic [N-1:0] s2;
        logic [N-1:0] prev;
        bit           quiet;
        bit           hold;
        @(posedge clk);
        raw_q.push_back(raw_in);
        s2 = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : '0;
        s2_q.push_back(s2);
        diff_q.push_back(s2 != m_clean);
        if (diff_q.size() > D) begin
            quiet = 1'b1;
            for (int k = diff_q.size() - 1 - D; k <= diff_q.size() - 2; k++)
                if (diff_q[k]) quiet = 1'b0;
            if (quiet) m_settled = 1'b1;
        end
        prev = m_clean;
        if (s2_q.size() >= D) begin
            for (int c = 0; c < N; c++) begin
                hold = 1'b1;
                for (int k = s2_q.size() - D; k < s2_q.size(); k++)
                    if (s2_q[k][c] == prev[c]) hold = 1'b0;
                if (hold) m_clean[c] = ~prev[c];
            end
        end
        m_rise = m_clean & ~prev;
        m_fall = prev & ~m_clean;
        if (raw_q.size() > 16) void'(raw_q.pop_front());
        if (s2_q.size() > 16) void'(s2_q.pop_front());
        if (diff_q.size() > 16) void'(diff_q.pop_front());
        #1;
    endtask

    task automatic test_reset();
        raw_in = '0;
        do_reset();
        total++;
        if ({clean_out, rise_pulse, fall_pulse, settled} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {clean_out, rise_pulse, fall_pulse, settled});
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL reset_model: edge %0d got %b want %b", i,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
            total++;
            if (settled !== 1'(i >= 5)) begin
                bad++;
                $display("FAIL reset_settled: edge %0d got %b want %b", i, settled, i >= 5);
            end
        end
        $display("test_reset: done, settled=%b", settled);
    endtask

    task automatic test_rise_latency();
        int lat = 0;
        int rises = 0;
        raw_in[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL rise_model: cycle %0d got %b want %b", k,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
            if (lat == 0 && clean_out[0]) lat = k;
            if (rise_pulse[0]) rises++;
        end
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL rise_latency: got %0d want 6", lat);
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL rise_pulse_count: got %0d want 1", rises);
        end
        $display("test_rise_latency: latency=%0d pulses=%0d", lat, rises);
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            raw_in[2] = (k < 3);
            step();
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL glitch_model: cycle %0d got %b want %b", k,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
            seen = seen | clean_out[2] | rise_pulse[2] | fall_pulse[2];
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_reject: ch2 activity got %b want 0", seen);
        end
        $display("test_glitch: ch2 activity=%b", seen);
    endtask

    task automatic test_simultaneous();
        int r1 = 0;
        int r5 = 0;
        raw_in[1] = 1'b1;
        raw_in[5] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL simul_model: cycle %0d got %b want %b", k,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
            if (r1 == 0 && rise_pulse[1]) r1 = k;
            if (r5 == 0 && rise_pulse[5]) r5 = k;
        end
        total++;
        if (r1 != 6 || r5 != 6) begin
            bad++;
            $display("FAIL simul_pulses: got ch1=%0d ch5=%0d want 6 and 6", r1, r5);
        end
        $display("test_simultaneous: ch1 pulse at %0d, ch5 pulse at %0d", r1, r5);
    endtask

    task automatic test_reset_mid();
        int falls = 0;
        raw_in[3] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        total++;
        if (clean_out[3] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_setup: clean3 got %b want 1", clean_out[3]);
        end
        raw_in[3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (fall_pulse[3]) falls++;
        end
        do_reset();
        total++;
        if ({clean_out, rise_pulse, fall_pulse, settled} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got %b want 0", {clean_out, rise_pulse, fall_pulse, settled});
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (fall_pulse[3]) falls++;
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL midrst_model: cycle %0d got %b want %b", k,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
        end
        total++;
        if (falls != 0) begin
            bad++;
            $display("FAIL midrst_fall: got %0d fall pulses want 0", falls);
        end
        $display("test_reset_mid: ch3 fall pulses=%0d", falls);
    endtask

    task automatic test_chatter();
        int rises = 0;
        int lat = 0;
        for (int i = 0; i < 20; i++) begin
            raw_in[6] = ((i / 2) % 2 == 0);
            step();
            if (rise_pulse[6]) rises++;
            total++;
            if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                bad++;
                $display("FAIL chatter_model: cycle %0d got %b want %b", i,
                         {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
            end
        end
        raw_in[6] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (rise_pulse[6]) rises++;
            if (lat == 0 && clean_out[6]) lat = k;
        end
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL chatter_latency: got %0d want 6", lat);
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL chatter_pulses: got %0d want 1", rises);
        end
        $display("test_chatter: latency=%0d pulses=%0d", lat, rises);
    endtask

    task automatic test_random();
        int hold = 0;
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                raw_in = N'($urandom);
                hold   = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
                total++;
                if ({clean_out, rise_pulse, fall_pulse, settled} !== '0) begin
                    bad++;
                    errs++;
                    $display("FAIL random_reset: got %b want 0", {clean_out, rise_pulse, fall_pulse, settled});
                end
            end else begin
                step();
                total++;
                if ({clean_out, rise_pulse, fall_pulse, settled} !== {m_clean, m_rise, m_fall, m_settled}) begin
                    bad++;
                    errs++;
                    $display("FAIL random_model: step %0d raw %b got %b want %b", k, raw_in,
                             {clean_out, rise_pulse, fall_pulse, settled}, {m_clean, m_rise, m_fall, m_settled});
                end
            end
        end
        $display("test_random: 400 steps, %0d errors", errs);
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        raw_in = '0;
        do_reset();
        for (int k = 0; k < 8; k++) step();
        test_chatter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
